// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one single-byte I2C master among N_REQ requesters.
// One transaction in flight at a time; completion or timeout is reported to the granted requester only.
module i2c_req_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     req_accept,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 m_enable,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    input  logic                 m_ready,
    input  logic [7:0]           m_rdata,
    output logic                 busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SAT    = TW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic            meta, rdy_s;
    logic [IW-1:0]   rr_ptr, rr_ptr_nx, grant, grant_nx, pick;
    logic            pick_ok;
    logic [TW-1:0]   timer, timer_nx, timer_inc;
    logic            tmo;
    logic [6:0]      addr_arr  [N_REQ];
    logic [7:0]      wdata_arr [N_REQ];

    logic [N_REQ-1:0] accept_nx, rsp_valid_nx;
    logic [7:0]       rsp_rdata_nx, m_wdata_nx;
    logic             rsp_err_nx, m_enable_nx, m_rw_nx;
    logic [6:0]       m_addr_nx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[7*gi +: 7];
        assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end

    assign tmo       = (timer == T_LAST);
    assign timer_inc = (timer == T_SAT) ? timer : timer + TW'(1);
    assign busy      = (state != IDLE);

    // Two-flop synchronizer for the master's ready, which runs on its own clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            meta  <= m_ready;
            rdy_s <= meta;
        end
    end

    // Round-robin pick: scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_b;
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        idx_b   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx   = (int'(rr_ptr) + i) % N_REQ;
            idx_b = IW'(idx);
            if (req_valid[idx_b]) begin
                pick    = idx_b;
                pick_ok = 1'b1;
            end else begin
                pick_ok = pick_ok;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (rdy_s && pick_ok) state_nx = ISSUE;     else state_nx = IDLE;
            ISSUE:     if (tmo)              state_nx = RESP;
                       else if (!rdy_s)      state_nx = WAIT_DONE;
                       else                  state_nx = ISSUE;
            WAIT_DONE: if (rdy_s || tmo)     state_nx = RESP;      else state_nx = WAIT_DONE;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Output and datapath next values; a completed transfer wins over a same-cycle timeout.
    always_comb begin
        accept_nx    = '0;
        rsp_valid_nx = '0;
        rsp_rdata_nx = rsp_rdata;
        rsp_err_nx   = rsp_err;
        m_enable_nx  = m_enable;
        m_addr_nx    = m_addr;
        m_rw_nx      = m_rw;
        m_wdata_nx   = m_wdata;
        grant_nx     = grant;
        rr_ptr_nx    = rr_ptr;
        timer_nx     = timer;
        case (state)
            IDLE: begin
                if (rdy_s && pick_ok) begin
                    grant_nx        = pick;
                    m_addr_nx       = addr_arr[pick];
                    m_rw_nx         = req_rw[pick];
                    m_wdata_nx      = wdata_arr[pick];
                    accept_nx[pick] = 1'b1;
                    m_enable_nx     = 1'b1;
                    timer_nx        = '0;
                end else begin
                    m_enable_nx = 1'b0;
                end
            end
            ISSUE: begin
                timer_nx = timer_inc;
                if (tmo) begin
                    m_enable_nx         = 1'b0;
                    rsp_rdata_nx        = 8'h00;
                    rsp_err_nx          = 1'b1;
                    rsp_valid_nx[grant] = 1'b1;
                end else if (!rdy_s) begin
                    m_enable_nx = 1'b0;
                end else begin
                    m_enable_nx = 1'b1;
                end
            end
            WAIT_DONE: begin
                timer_nx    = timer_inc;
                m_enable_nx = 1'b0;
                if (rdy_s) begin
                    rsp_rdata_nx        = m_rw ? m_rdata : 8'h00;
                    rsp_err_nx          = 1'b0;
                    rsp_valid_nx[grant] = 1'b1;
                end else if (tmo) begin
                    rsp_rdata_nx        = 8'h00;
                    rsp_err_nx          = 1'b1;
                    rsp_valid_nx[grant] = 1'b1;
                end else begin
                    rsp_err_nx = rsp_err;
                end
            end
            RESP: begin
                rr_ptr_nx = (grant == LAST_IDX) ? '0 : grant + IW'(1);
            end
            default: begin
                m_enable_nx = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_accept <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= 8'h00;
            rsp_err    <= 1'b0;
            m_enable   <= 1'b0;
            m_addr     <= 7'h00;
            m_rw       <= 1'b0;
            m_wdata    <= 8'h00;
            grant      <= '0;
            rr_ptr     <= '0;
            timer      <= '0;
        end else begin
            req_accept <= accept_nx;
            rsp_valid  <= rsp_valid_nx;
            rsp_rdata  <= rsp_rdata_nx;
            rsp_err    <= rsp_err_nx;
            m_enable   <= m_enable_nx;
            m_addr     <= m_addr_nx;
            m_rw       <= m_rw_nx;
            m_wdata    <= m_wdata_nx;
            grant      <= grant_nx;
            rr_ptr     <= rr_ptr_nx;
            timer      <= timer_nx;
        end
    end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one I2C master among N_REQ requesters, one single-byte transaction at a time.
- Arbitration is round-robin.
- For each granted request the block:
  - latches the address, direction and write byte;
  - drives the master's enable/addr/rw/data_in;
  - waits for the master to go busy and return to idle;
  - returns read data or a timeout error to the granted requester only.
- Sits between system-side requesters (sensor pollers, config sequencer) and the I2C master.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, clk cycles allowed from ISSUE entry to transaction completion before error.

Ports:
- clk  input  1  system clock; master's ready is treated as asynchronous to it.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N_REQ  per-requester request; held with payload until req_accept.
- req_addr  input  7*N_REQ  7-bit target address, slice i = [7i+6:7i].
- req_rw  input  N_REQ  1 = read, 0 = write.
- req_wdata  input  8*N_REQ  write byte, slice i = [8i+7:8i].
- req_accept  output  N_REQ  one-cycle pulse on the granted bit when the request is latched.
- rsp_valid  output  N_REQ  one-cycle pulse on the granted bit at completion.
- rsp_rdata  output  8  read byte; valid with rsp_valid; 0 for writes and on error.
- rsp_err  output  1  timeout flag; valid with rsp_valid.
- m_enable  output  1  to master enable.
- m_addr  output  7  to master addr.
- m_rw  output  1  to master rw.
- m_wdata  output  8  to master data_in.
- m_ready  input  1  from master ready (high = idle).
- m_rdata  input  8  from master data_out.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0; timer = 0; state IDLE; both synchronizer flops 0.
- m_ready passes through a 2-flop synchronizer; rdy_s below is the synchronized value. m_rdata is sampled only when rdy_s has been high for that transaction, i.e. it is stable.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.

IDLE
- If rdy_s = 1 and req_valid != 0, select the first set bit searching from index rr_ptr upward, wrapping modulo N_REQ.
- Latch addr/rw/wdata of the granted index g into m_addr/m_rw/m_wdata.
- Pulse req_accept[g] for one cycle; clear timer; go ISSUE.
- If rdy_s = 0, no grant is made.

ISSUE
- m_enable = 1; timer increments each cycle.
- rdy_s = 0 → m_enable <= 0, go WAIT_DONE.
- m_enable must drop as soon as busy is seen; the master restarts if enable is still high at its ack phase.

WAIT_DONE
- m_enable = 0; timer keeps counting.
- rdy_s = 1 → rsp_rdata <= (m_rw ? m_rdata : 0), rsp_err <= 0, go RESP.

Timeout
- In ISSUE or WAIT_DONE, timer == TIMEOUT_CYCLES-1 → m_enable <= 0, rsp_rdata <= 0, rsp_err <= 1, go RESP.

RESP
- Pulse rsp_valid[g] for one cycle; rr_ptr <= (g+1) mod N_REQ; go IDLE.
- rsp_rdata/rsp_err hold until the next RESP.

Rules
- Only one transaction is in flight; new or changed req_valid is ignored outside IDLE.
- A requester still asserting valid after its response is re-arbitrated fairly behind the others.
- Timer width is clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.
- m_addr/m_rw/m_wdata stay stable from ISSUE entry until the next grant.
- Reset mid-transaction: immediate return to reset values, no rsp_valid pulse; the pending requester must re-request.

Test Plan:
- Single write: req_valid[1]=1, addr=0x50, rw=0, wdata=0xA5.
  → req_accept[1] pulses, m_enable high until rdy_s falls.
  → master sees addr 0x50 and byte 0xA5; rsp_valid[1] pulses with rsp_err=0, rsp_rdata=0x00.
- Single read: req 2 reads addr 0x3C; slave returns 0x5A.
  → rsp_valid[2] pulses with rsp_rdata=0x5A, rsp_err=0.
- Round robin: req_valid=4'b1111 held continuously.
  → grant order 0,1,2,3,0; exactly one req_accept and one rsp_valid per transaction, never overlapping.
- Timeout: master stub holds m_ready=1 forever (TIMEOUT_CYCLES=64).
  → rsp_valid pulses 64 cycles after ISSUE entry, rsp_err=1, m_enable=0.
- Enable release: the master must not re-run the transaction.
  → m_enable deasserts within 3 clk of m_ready falling; exactly one START observed on the bus per grant.
- Async reset mid-WAIT_DONE: rst=1 for 2 cycles.
  → all outputs 0 immediately; after release, a held req_valid[3] is re-granted from rr_ptr=0.
